mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory port between the fetch stage (`pc`, two instructions per 64-bit word) and the data path (LSQ loads and stores). Data requests win by default. A starvation counter forces a fetch grant after a bounded wait. The block owns the tag table that routes each memory completion back to its requester. It drives `memory_structure_hazard_stall` into `pc` and discards wrong-path fetch completions after `branch_is_taken`.

## Interface

Parameters:
- `STARVE_MAX`, 3: consecutive denied fetch cycles after which fetch gets priority.
- `MAX_IF_OUT`, 4: maximum outstanding fetch transactions.

Ports:
- `clock` in 1: system clock, all state updates on posedge.
- `reset` in 1: asynchronous, active-low; state clears while `reset`=0.
- `if_req` in 1: fetch wants the word at `if_addr`.
- `if_addr` in 64: fetch address, 8-byte aligned.
- `d_cmd` in 2: 00 none, 01 load, 10 store, 11 illegal (treated as none).
- `d_addr` in 64: data address.
- `d_wdata` in 64: store data.
- `branch_is_taken` in 1: squash all in-flight fetches.
- `mem2proc_response` in 4: nonzero means the command was accepted with this tag; 0 means rejected.
- `mem2proc_tag` in 4: nonzero means the transaction with this tag has completed.
- `mem2proc_data` in 64: completion data.
- `proc2mem_command` out 2: command to memory.
- `proc2mem_addr` out 64: address to memory.
- `proc2mem_data` out 64: write data to memory.
- `if_grant` out 1: fetch accepted by memory this cycle.
- `d_grant` out 1: data request accepted by memory this cycle.
- `memory_structure_hazard_stall` out 1: `if_req` && !`if_grant`.
- `if_data_valid` out 1: `resp_data` holds a live fetch word.
- `d_data_valid` out 1: `resp_data` holds load data.
- `resp_data` out 64: `mem2proc_data` passthrough.
- `if_outstanding` out 3: count of live and stale fetches in flight.

## Operation

Selection is combinational each cycle:
- `fetch_ok` = `if_req` && `if_outstanding` < `MAX_IF_OUT`.
- `d_valid` = `d_cmd` ∈ {01, 10}.
- If `fetch_ok` && `d_valid`: fetch is chosen iff `starve_cnt` == `STARVE_MAX`; otherwise data is chosen.
- If only one requester is valid, it is chosen.
- If neither is valid, `proc2mem_command` = 00.

Chosen request drives the memory port:
- Fetch drives command 01 (load) with `if_addr`.
- Data drives `d_cmd`, `d_addr` and `d_wdata`.
- `proc2mem_data` = 0 unless the command is a store.

Grant and allocation:
- Grant = chosen && `mem2proc_response` != 0.
- A granted load or fetch writes table[`mem2proc_response`] = {valid=1, owner (0 fetch / 1 data), stale = `branch_is_taken`}.
- Stores are not entered in the table. Their completions are ignored.

Completion:
- When `mem2proc_tag` != 0, read table[`mem2proc_tag`].
- If valid, owner fetch, not stale: `if_data_valid`=1.
- If valid, owner data: `d_data_valid`=1.
- The entry is cleared in every case.
- A stale fetch completion, or a completion on an invalid entry, raises no valid output.

Squash:
- `branch_is_taken` sets stale=1 on every valid fetch entry.
- It also suppresses `if_data_valid` in that same cycle.

Starvation counter `starve_cnt` (2 bits, saturating at `STARVE_MAX`):
- Increments when `fetch_ok` && !`if_grant`.
- Clears when fetch is granted or `if_req`=0.

`if_outstanding`:
- +1 on a fetch grant.
- −1 on any fetch completion, stale or not.
- Both in the same cycle: no change.

## Timing

- Grant, stall, command and completion outputs are combinational in the same cycle. Table, counter and count update at posedge.
- Reset values:
  - `if_grant`, `d_grant`, `if_data_valid`, `d_data_valid` = 0.
  - `proc2mem_command` = 00.
  - `if_outstanding` = 0.
  - `memory_structure_hazard_stall` = `if_req`.
  - All table entries invalid; `starve_cnt` = 0.
- Reset mid-operation: completions arriving after reset hit invalid entries and are dropped silently.
- Same tag completing and allocated in one cycle: completion reads the old entry, then allocation overwrites it (allocation wins).
- Memory rejects (`mem2proc_response`=0): no grant. Fetch stalls and `starve_cnt` still advances.
- Fetch requested while `if_outstanding` == `MAX_IF_OUT`: fetch is not presented to memory, stall=1, `starve_cnt` holds.

## Test plan

- Reset low with `if_req`=1: all grants 0, command 00, stall 1. Completion tag 5 after release produces no valid output.
- Fetch only, response tag 3; tag 3 completes 2 cycles later with data 64'h1234_4567_5678_3456: `if_grant`=1 then `if_data_valid`=1, `if_outstanding` goes 1→0.
- Fetch plus continuous loads, memory accepts every cycle: data wins 3 cycles with stall=1, fetch granted on cycle 4, `starve_cnt` back to 0.
- Fetch granted with tag 2, `branch_is_taken`=1 next cycle, tag 2 completes: `if_data_valid`=0, `if_outstanding` decrements.
- Four fetches accepted, none completed, fifth `if_req`: command 00 if no data request, stall=1. One completion, then fetch is granted the following cycle.
- Store with tag 7 then completion tag 7: `d_grant`=1, no `d_data_valid`. A load with tag 7 allocated in the completion cycle completes later with `d_data_valid`=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the request, memory-port and completion signals of
// mem_arbiter so they can be passed as a single port.
//   slave  - arbiter side: consumes fetch/data requests and memory replies,
//            drives the memory command and the per-requester results.
//   master - environment side: fetch stage, LSQ and memory model.
interface mem_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic [1:0]  d_cmd;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        branch_is_taken;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;

    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        if_grant;
    logic        d_grant;
    logic        memory_structure_hazard_stall;
    logic        if_data_valid;
    logic        d_data_valid;
    logic [63:0] resp_data;
    logic [2:0]  if_outstanding;

    modport slave (
        input  if_req, if_addr, d_cmd, d_addr, d_wdata, branch_is_taken,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, if_grant,
               d_grant, memory_structure_hazard_stall, if_data_valid,
               d_data_valid, resp_data, if_outstanding
    );

    modport master (
        output if_req, if_addr, d_cmd, d_addr, d_wdata, branch_is_taken,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, if_grant,
               d_grant, memory_structure_hazard_stall, if_data_valid,
               d_data_valid, resp_data, if_outstanding
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// data path. Data wins by default; a saturating starvation counter hands the
// port to fetch after STARVE_MAX consecutive denied fetch cycles. A 16-entry
// tag table (tag 0 unused) routes completions back to their requester and
// marks fetches as stale on a taken branch so wrong-path words are dropped.
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: requests, memory port, completion results
module mem_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int MAX_IF_OUT = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);
    localparam logic [2:0] IF_OUT_LIM = 3'(MAX_IF_OUT);

    // Tag table; owner 0 = fetch, 1 = data.
    logic [15:0] tbl_valid;
    logic [15:0] tbl_owner;
    logic [15:0] tbl_stale;
    logic [1:0]  starve_cnt;
    logic [2:0]  if_out_cnt;

    logic fetch_ok;
    logic d_valid;
    logic pick_fetch;
    logic pick_data;
    logic alloc;
    logic cpl_hit;
    logic cpl_fetch;

    always_comb begin
        fetch_ok   = bus.if_req && (if_out_cnt < IF_OUT_LIM);
        d_valid    = (bus.d_cmd == 2'b01) || (bus.d_cmd == 2'b10);
        // Nothing reaches memory while reset is held.
        pick_fetch = reset && fetch_ok && (!d_valid || (starve_cnt == STARVE_LIM));
        pick_data  = reset && d_valid && !pick_fetch;

        bus.proc2mem_command = 2'b00;
        bus.proc2mem_addr    = 64'd0;
        bus.proc2mem_data    = 64'd0;
        if (pick_fetch) begin
            bus.proc2mem_command = 2'b01;
            bus.proc2mem_addr    = bus.if_addr;
        end else if (pick_data) begin
            bus.proc2mem_command = bus.d_cmd;
            bus.proc2mem_addr    = bus.d_addr;
            if (bus.d_cmd == 2'b10) begin
                bus.proc2mem_data = bus.d_wdata;
            end
        end

        bus.if_grant = pick_fetch && (bus.mem2proc_response != 4'd0);
        bus.d_grant  = pick_data && (bus.mem2proc_response != 4'd0);
        bus.memory_structure_hazard_stall = bus.if_req && !bus.if_grant;

        // Stores never enter the table.
        alloc = bus.if_grant || (bus.d_grant && (bus.d_cmd == 2'b01));

        cpl_hit   = (bus.mem2proc_tag != 4'd0) && tbl_valid[bus.mem2proc_tag];
        cpl_fetch = cpl_hit && !tbl_owner[bus.mem2proc_tag];
        bus.if_data_valid = cpl_fetch && !tbl_stale[bus.mem2proc_tag]
                            && !bus.branch_is_taken;
        bus.d_data_valid  = cpl_hit && tbl_owner[bus.mem2proc_tag];
        bus.resp_data     = bus.mem2proc_data;
        bus.if_outstanding = if_out_cnt;
    end

    // Table update order matters: squash, then completion clear, then
    // allocation, so a tag retired and reissued in one cycle keeps the new entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tbl_valid <= '0;
            tbl_owner <= '0;
            tbl_stale <= '0;
        end else begin
            if (bus.branch_is_taken) begin
                tbl_stale <= tbl_stale | (tbl_valid & ~tbl_owner);
            end
            if (bus.mem2proc_tag != 4'd0) begin
                tbl_valid[bus.mem2proc_tag] <= 1'b0;
            end
            if (alloc) begin
                tbl_valid[bus.mem2proc_response] <= 1'b1;
                tbl_owner[bus.mem2proc_response] <= pick_data;
                tbl_stale[bus.mem2proc_response] <= bus.branch_is_taken;
            end
        end
    end

    // Holds (rather than advancing) while fetch is blocked by the outstanding limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 2'd0;
        end else if (!bus.if_req || bus.if_grant) begin
            starve_cnt <= 2'd0;
        end else if (fetch_ok && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end

    // Stale fetches still count until memory returns them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_out_cnt <= 3'd0;
        end else begin
            case ({bus.if_grant, cpl_fetch})
                2'b10:   if_out_cnt <= if_out_cnt + 3'd1;
                2'b01:   if_out_cnt <= if_out_cnt - 3'd1;
                default: if_out_cnt <= if_out_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset behaviour, fetch-only path,
// starvation override, rejects, squash, outstanding limit, store/load tags,
// and reset mid-operation.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(3), .MAX_IF_OUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        bus.if_req            = 1'b0;
        bus.if_addr           = 64'd0;
        bus.d_cmd             = 2'b00;
        bus.d_addr            = 64'd0;
        bus.d_wdata           = 64'd0;
        bus.branch_is_taken   = 1'b0;
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd0;
        bus.mem2proc_data     = 64'd0;
    endtask

    initial begin
        // Reset held with both requesters active and memory willing.
        reset = 1'b0;
        idle();
        bus.if_req = 1'b1;
        bus.d_cmd = 2'b01;
        bus.mem2proc_response = 4'd1;
        #3;
        chk("rst_if_grant", bus.if_grant, 0);
        chk("rst_d_grant", bus.d_grant, 0);
        chk("rst_cmd", bus.proc2mem_command, 0);
        chk("rst_stall", bus.memory_structure_hazard_stall, 1);
        chk("rst_outstanding", bus.if_outstanding, 0);
        tick();
        tick();
        chk("rst_cmd_held", bus.proc2mem_command, 0);
        reset = 1'b1;
        idle();
        bus.mem2proc_tag = 4'd5;
        bus.mem2proc_data = 64'hAAAA;
        #1;
        chk("rst_tag5_ifv", bus.if_data_valid, 0);
        chk("rst_tag5_dv", bus.d_data_valid, 0);
        tick();
        chk("rst_tag5_out", bus.if_outstanding, 0);

        // Fetch only, tag 3, completes two cycles later.
        idle();
        bus.if_req = 1'b1;
        bus.if_addr = 64'h1000;
        bus.mem2proc_response = 4'd3;
        #1;
        chk("f_cmd", bus.proc2mem_command, 1);
        chk("f_addr", bus.proc2mem_addr, 64'h1000);
        chk("f_wdata", bus.proc2mem_data, 0);
        chk("f_grant", bus.if_grant, 1);
        chk("f_stall", bus.memory_structure_hazard_stall, 0);
        tick();
        chk("f_out1", bus.if_outstanding, 1);
        idle();
        #1;
        chk("f_idle_cmd", bus.proc2mem_command, 0);
        tick();
        bus.mem2proc_tag = 4'd3;
        bus.mem2proc_data = 64'h1234_4567_5678_3456;
        #1;
        chk("f_ifv", bus.if_data_valid, 1);
        chk("f_dv", bus.d_data_valid, 0);
        chk("f_resp", bus.resp_data, 64'h1234_4567_5678_3456);
        tick();
        chk("f_out0", bus.if_outstanding, 0);

        // Fetch vs continuous loads, memory accepts every cycle.
        idle();
        bus.if_req = 1'b1;
        bus.if_addr = 64'h2000;
        bus.d_cmd = 2'b01;
        bus.d_addr = 64'h3000;
        for (int c = 0; c < 3; c++) begin
            bus.mem2proc_response = 4'(8 + c);
            #1;
            chk("sv_d_grant", bus.d_grant, 1);
            chk("sv_if_grant", bus.if_grant, 0);
            chk("sv_stall", bus.memory_structure_hazard_stall, 1);
            chk("sv_addr", bus.proc2mem_addr, 64'h3000);
            tick();
        end
        bus.mem2proc_response = 4'd11;
        #1;
        chk("sv4_if_grant", bus.if_grant, 1);
        chk("sv4_d_grant", bus.d_grant, 0);
        chk("sv4_addr", bus.proc2mem_addr, 64'h2000);
        chk("sv4_stall", bus.memory_structure_hazard_stall, 0);
        tick();
        bus.mem2proc_response = 4'd12;
        #1;
        chk("sv5_cnt_cleared", bus.d_grant, 1);
        tick();
        idle();
        bus.mem2proc_tag = 4'd8;
        bus.mem2proc_data = 64'h88;
        #1;
        chk("ld8_dv", bus.d_data_valid, 1);
        chk("ld8_ifv", bus.if_data_valid, 0);
        tick();
        bus.mem2proc_tag = 4'd11;
        #1;
        chk("f11_ifv", bus.if_data_valid, 1);
        tick();
        chk("sv_out0", bus.if_outstanding, 0);

        // Rejects still advance the starvation counter.
        idle();
        bus.if_req = 1'b1;
        bus.if_addr = 64'h2800;
        bus.d_cmd = 2'b01;
        bus.d_addr = 64'h3800;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rj_addr_data", bus.proc2mem_addr, 64'h3800);
            chk("rj_no_grant", bus.d_grant, 0);
            tick();
        end
        #1;
        chk("rj_fetch_pick", bus.proc2mem_addr, 64'h2800);
        chk("rj_if_grant0", bus.if_grant, 0);
        tick();
        bus.mem2proc_response = 4'd15;
        #1;
        chk("rj_sat_grant", bus.if_grant, 1);
        tick();
        idle();
        bus.mem2proc_tag = 4'd15;
        #1;
        chk("rj_f15_ifv", bus.if_data_valid, 1);
        tick();

        // Squash: fetch tag 2, branch next cycle, completion dropped.
        idle();
        bus.if_req = 1'b1;
        bus.mem2proc_response = 4'd2;
        #1;
        chk("sq_grant", bus.if_grant, 1);
        tick();
        idle();
        bus.branch_is_taken = 1'b1;
        tick();
        idle();
        bus.mem2proc_tag = 4'd2;
        #1;
        chk("sq_ifv", bus.if_data_valid, 0);
        chk("sq_out_before", bus.if_outstanding, 1);
        tick();
        chk("sq_out_after", bus.if_outstanding, 0);
        // Completion in the branch cycle is suppressed.
        idle();
        bus.if_req = 1'b1;
        bus.mem2proc_response = 4'd4;
        tick();
        idle();
        bus.mem2proc_tag = 4'd4;
        bus.branch_is_taken = 1'b1;
        #1;
        chk("sq_same_ifv", bus.if_data_valid, 0);
        tick();
        chk("sq_same_out", bus.if_outstanding, 0);
        // Fetch granted during a branch is born stale.
        idle();
        bus.if_req = 1'b1;
        bus.branch_is_taken = 1'b1;
        bus.mem2proc_response = 4'd6;
        tick();
        idle();
        bus.mem2proc_tag = 4'd6;
        #1;
        chk("sq_born_stale", bus.if_data_valid, 0);
        tick();
        chk("sq_born_out", bus.if_outstanding, 0);

        // Outstanding limit.
        idle();
        bus.if_req = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            bus.mem2proc_response = 4'(t);
            #1;
            chk("lim_grant", bus.if_grant, 1);
            tick();
        end
        chk("lim_out4", bus.if_outstanding, 4);
        bus.mem2proc_response = 4'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lim_cmd", bus.proc2mem_command, 0);
            chk("lim_stall", bus.memory_structure_hazard_stall, 1);
            tick();
        end
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag = 4'd1;
        #1;
        chk("lim_cpl_ifv", bus.if_data_valid, 1);
        tick();
        chk("lim_out3", bus.if_outstanding, 3);
        // Counter held while blocked, so data still wins here.
        bus.mem2proc_tag = 4'd0;
        bus.d_cmd = 2'b01;
        bus.mem2proc_response = 4'd13;
        #1;
        chk("lim_hold_dgrant", bus.d_grant, 1);
        tick();
        bus.d_cmd = 2'b00;
        bus.mem2proc_response = 4'd1;
        #1;
        chk("lim_refetch", bus.if_grant, 1);
        tick();
        idle();
        for (int t = 1; t <= 4; t++) begin
            bus.mem2proc_tag = 4'(t);
            #1;
            chk("lim_drain_ifv", bus.if_data_valid, 1);
            tick();
        end
        chk("lim_out0", bus.if_outstanding, 0);

        // Illegal data command is ignored.
        idle();
        bus.d_cmd = 2'b11;
        bus.mem2proc_response = 4'd9;
        #1;
        chk("ill_cmd", bus.proc2mem_command, 0);
        chk("ill_grant", bus.d_grant, 0);
        tick();

        // Store tag 7, then load reusing tag 7 in the completion cycle.
        idle();
        bus.d_cmd = 2'b10;
        bus.d_addr = 64'h5000;
        bus.d_wdata = 64'hDEAD_BEEF;
        bus.mem2proc_response = 4'd7;
        #1;
        chk("st_grant", bus.d_grant, 1);
        chk("st_cmd", bus.proc2mem_command, 2);
        chk("st_wdata", bus.proc2mem_data, 64'hDEAD_BEEF);
        tick();
        bus.d_cmd = 2'b01;
        bus.d_addr = 64'h6000;
        bus.mem2proc_tag = 4'd7;
        #1;
        chk("st_cpl_dv", bus.d_data_valid, 0);
        chk("ld7_grant", bus.d_grant, 1);
        chk("ld7_wdata0", bus.proc2mem_data, 0);
        tick();
        idle();
        bus.mem2proc_tag = 4'd7;
        bus.mem2proc_data = 64'hCAFE;
        #1;
        chk("ld7_dv", bus.d_data_valid, 1);
        chk("ld7_resp", bus.resp_data, 64'hCAFE);
        tick();

        // Reset mid-operation drops the in-flight fetch.
        idle();
        bus.if_req = 1'b1;
        bus.mem2proc_response = 4'd14;
        tick();
        idle();
        reset = 1'b0;
        #1;
        chk("mrst_out", bus.if_outstanding, 0);
        tick();
        reset = 1'b1;
        bus.mem2proc_tag = 4'd14;
        #1;
        chk("mrst_ifv", bus.if_data_valid, 0);
        tick();
        chk("mrst_out_after", bus.if_outstanding, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
